// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket machine transaction controller:
// FSM state encoding, coin values, default prices and limits.
package ticket_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_DISPENSE = 3'd2,
      ST_SHOW     = 3'd3,
      ST_ERR      = 3'd4
   } state_e;

   localparam logic [4:0] COIN1_VAL  = 5'd1;
   localparam logic [4:0] COIN5_VAL  = 5'd5;
   localparam logic [4:0] COIN10_VAL = 5'd10;

   localparam int DEF_PRICE0    = 2;
   localparam int DEF_PRICE1    = 3;
   localparam int DEF_PRICE2    = 5;
   localparam int DEF_PRICE3    = 8;
   localparam int DEF_MAX_PAID  = 99;
   localparam int DEF_SALES_MAX = 9999;
   localparam int DEF_HOLD_CYC  = 200;

   // Value of all coin pulses seen in one cycle (simultaneous pulses add up).
   function automatic logic [4:0] calc_coin_sum(input logic c1, input logic c5, input logic c10);
      logic [4:0] sum;
      sum = 5'd0;
      if (c1)  sum = sum + COIN1_VAL;
      if (c5)  sum = sum + COIN5_VAL;
      if (c10) sum = sum + COIN10_VAL;
      return sum;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that times how long SHOW and ERR persist. A load starts a
// hold of HOLD_CYC cycles; done is high during the last cycle of the hold.
module hold_timer #(
   parameter int HOLD_CYC = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic count_i,
   output logic done_o
);

   localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYC - 1);

   logic [CW-1:0] cnt_q;

   // Load on entry to a hold state, then count down to zero while holding.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= LOAD_VAL;
      end else if (count_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ticket_ctrl.sv
// Ticket machine transaction controller: collects coins, checks the price of
// the selected ticket, dispenses, shows change, and keeps a saturating sales
// total. Sits between the input debouncer and the display/LED drivers.
module ticket_ctrl
   import ticket_pkg::*;
#(
   parameter int PRICE0    = DEF_PRICE0,
   parameter int PRICE1    = DEF_PRICE1,
   parameter int PRICE2    = DEF_PRICE2,
   parameter int PRICE3    = DEF_PRICE3,
   parameter int MAX_PAID  = DEF_MAX_PAID,
   parameter int SALES_MAX = DEF_SALES_MAX,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_sales,
   input  logic        coin1,
   input  logic        coin5,
   input  logic        coin10,
   input  logic [3:0]  ticket_sel,
   input  logic        confirm,
   output logic [6:0]  paid,
   output logic [3:0]  price,
   output logic [6:0]  change,
   output logic [13:0] sales,
   output logic        ticket_out,
   output logic        coin_reject,
   output logic        err,
   output logic [2:0]  state
);

   localparam logic [3:0]  P0_W        = 4'(PRICE0);
   localparam logic [3:0]  P1_W        = 4'(PRICE1);
   localparam logic [3:0]  P2_W        = 4'(PRICE2);
   localparam logic [3:0]  P3_W        = 4'(PRICE3);
   localparam logic [7:0]  MAX_PAID_W  = 8'(MAX_PAID);
   localparam logic [14:0] SALES_MAX_W = 15'(SALES_MAX);

   state_e      state_q, state_d;
   logic        confirm_d_q;
   logic        conf_rise;
   logic [6:0]  paid_q, paid_d;
   logic [6:0]  change_q, change_d;
   logic [13:0] sales_q, sales_d;
   logic        ticket_out_q, ticket_out_d;
   logic        coin_reject_q, coin_reject_d;

   logic [3:0]  price_w;
   logic [4:0]  coin_sum_w;
   logic        coin_any;
   logic [7:0]  paid_sum;
   logic        coin_fits;
   logic [6:0]  paid_eff;
   logic [14:0] sales_sum;
   logic [13:0] sales_sat;
   logic        hold_load, hold_count, hold_done;

   hold_timer #(
      .HOLD_CYC (HOLD_CYC)
   ) u_hold_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (hold_load),
      .count_i (hold_count),
      .done_o  (hold_done)
   );

   // Price lookup: a one-hot selection picks its price, anything else is invalid (0).
   always_comb begin
      case (ticket_sel)
         4'b0001: price_w = P0_W;
         4'b0010: price_w = P1_W;
         4'b0100: price_w = P2_W;
         4'b1000: price_w = P3_W;
         default: price_w = '0;
      endcase
   end

   // Shared arithmetic: coin accumulation at 8 bits, sales add at 15 bits with saturation.
   always_comb begin
      conf_rise  = confirm & ~confirm_d_q;
      coin_sum_w = calc_coin_sum(coin1, coin5, coin10);
      coin_any   = coin1 | coin5 | coin10;
      paid_sum   = {1'b0, paid_q} + {3'b000, coin_sum_w};
      coin_fits  = (paid_sum <= MAX_PAID_W);
      paid_eff   = coin_fits ? paid_sum[6:0] : paid_q;
      sales_sum  = {1'b0, sales_q} + {11'd0, price_w};
      sales_sat  = (sales_sum > SALES_MAX_W) ? SALES_MAX_W[13:0] : sales_sum[13:0];
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         confirm_d_q   <= 1'b0;
         paid_q        <= '0;
         change_q      <= '0;
         sales_q       <= '0;
         ticket_out_q  <= 1'b0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         confirm_d_q   <= confirm;
         paid_q        <= paid_d;
         change_q      <= change_d;
         sales_q       <= sales_d;
         ticket_out_q  <= ticket_out_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   // Next-state logic; confirm is compared against the paid amount after this cycle's coins.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (coin_any) state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (conf_rise) begin
               if ((price_w == '0) || (paid_eff < {3'b000, price_w})) state_d = ST_ERR;
               else                                                   state_d = ST_DISPENSE;
            end
         end
         ST_DISPENSE: state_d = ST_SHOW;
         ST_SHOW: begin
            if (hold_done) state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (hold_done) state_d = ST_COLLECT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-state datapath updates, registered pulse outputs and hold timer control.
   always_comb begin
      paid_d        = paid_q;
      change_d      = change_q;
      sales_d       = sales_q;
      ticket_out_d  = 1'b0;
      coin_reject_d = 1'b0;
      hold_load     = 1'b0;
      hold_count    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (coin_any) paid_d = {2'b00, coin_sum_w};
         end
         ST_COLLECT: begin
            paid_d        = paid_eff;
            coin_reject_d = coin_any & ~coin_fits;
            ticket_out_d  = (state_d == ST_DISPENSE);
            hold_load     = (state_d == ST_ERR);
         end
         ST_DISPENSE: begin
            change_d      = paid_q - {3'b000, price_w};
            sales_d       = sales_sat;
            hold_load     = 1'b1;
            coin_reject_d = coin_any;
         end
         ST_SHOW: begin
            coin_reject_d = coin_any;
            hold_count    = 1'b1;
            if (hold_done) begin
               change_d = '0;
               paid_d   = '0;
            end
         end
         ST_ERR: begin
            coin_reject_d = coin_any;
            hold_count    = 1'b1;
         end
         default: ;
      endcase
      // Clearing the total wins over a same-cycle sale.
      if (clr_sales) sales_d = '0;
   end

   // Output mapping.
   always_comb begin
      paid        = paid_q;
      price       = price_w;
      change      = change_q;
      sales       = sales_q;
      ticket_out  = ticket_out_q;
      coin_reject = coin_reject_q;
      err         = (state_q == ST_ERR);
      state       = state_q;
   end

endmodule

// File: tb/tb_ticket_ctrl.sv
// Self-checking bench for ticket_ctrl: directed sale scenarios plus random
// traffic, compared every cycle against a behavioural model of the machine.
module tb_ticket_ctrl;

   localparam int HOLD = 6;

   localparam int S_IDLE     = 0;
   localparam int S_COLLECT  = 1;
   localparam int S_DISPENSE = 2;
   localparam int S_SHOW     = 3;
   localparam int S_ERR      = 4;

   logic        clk, rst_n, clr_sales, coin1, coin5, coin10, confirm;
   logic [3:0]  ticket_sel;
   logic [6:0]  paid, change;
   logic [3:0]  price;
   logic [13:0] sales;
   logic        ticket_out, coin_reject, err;
   logic [2:0]  state;

   ticket_ctrl #(.HOLD_CYC(HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_sales   (clr_sales),
      .coin1       (coin1),
      .coin5       (coin5),
      .coin10      (coin10),
      .ticket_sel  (ticket_sel),
      .confirm     (confirm),
      .paid        (paid),
      .price       (price),
      .change      (change),
      .sales       (sales),
      .ticket_out  (ticket_out),
      .coin_reject (coin_reject),
      .err         (err),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural model: machine mode, amounts and remaining hold cycles as plain integers.
   int m_st, m_paid, m_change, m_sales, m_hold;
   bit m_conf_prev, m_tick, m_rej;

   logic [3:0] cur_sel;
   bit         cur_conf;

   function automatic int price_of(input logic [3:0] s);
      case (s)
         4'b0001: return 2;
         4'b0010: return 3;
         4'b0100: return 5;
         4'b1000: return 8;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_paid = 0; m_change = 0; m_sales = 0; m_hold = 0;
      m_conf_prev = 0; m_tick = 0; m_rej = 0;
   endtask

   task automatic model_step();
      int  csum, pr;
      bit  rise, n_tick, n_rej;
      rise   = confirm && !m_conf_prev;
      csum   = int'(coin1) + 5 * int'(coin5) + 10 * int'(coin10);
      pr     = price_of(ticket_sel);
      n_tick = 0;
      n_rej  = 0;
      case (m_st)
         S_IDLE: if (csum > 0) begin m_paid = csum; m_st = S_COLLECT; end
         S_COLLECT: begin
            if (m_paid + csum <= 99) m_paid = m_paid + csum;
            else                     n_rej = 1;
            if (rise) begin
               if (pr == 0 || m_paid < pr) begin m_st = S_ERR; m_hold = HOLD; end
               else begin m_st = S_DISPENSE; n_tick = 1; end
            end
         end
         S_DISPENSE: begin
            m_change = (m_paid - pr) & 127;
            m_sales  = (m_sales + pr > 9999) ? 9999 : m_sales + pr;
            m_st     = S_SHOW;
            m_hold   = HOLD;
            n_rej    = (csum > 0);
         end
         S_SHOW: begin
            n_rej  = (csum > 0);
            m_hold = m_hold - 1;
            if (m_hold == 0) begin m_change = 0; m_paid = 0; m_st = S_IDLE; end
         end
         S_ERR: begin
            n_rej  = (csum > 0);
            m_hold = m_hold - 1;
            if (m_hold == 0) m_st = S_COLLECT;
         end
         default: ;
      endcase
      if (clr_sales) m_sales = 0;
      m_tick      = n_tick;
      m_rej       = n_rej;
      m_conf_prev = confirm;
   endtask

   task automatic compare_all();
      check("state",       state,       m_st);
      check("paid",        paid,        m_paid);
      check("change",      change,      m_change);
      check("sales",       sales,       m_sales);
      check("ticket_out",  ticket_out,  m_tick);
      check("coin_reject", coin_reject, m_rej);
      check("err",         err,         (m_st == S_ERR));
      check("price",       price,       price_of(ticket_sel));
   endtask

   // One clock cycle: drive at the falling edge, step the model, compare after the rising edge.
   task automatic drive(input bit c1, input bit c5, input bit c10, input bit clr);
      @(negedge clk);
      coin1 = c1; coin5 = c5; coin10 = c10; clr_sales = clr;
      ticket_sel = cur_sel; confirm = cur_conf;
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_n(input int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask

   task automatic coin(input int v);
      drive(v == 1, v == 5, v == 10, 0);
   endtask

   task automatic set_conf(input bit v);
      cur_conf = v;
      drive(0, 0, 0, 0);
   endtask

   task automatic wait_state(input int s, input string tag);
      int k;
      k = 0;
      while (state !== 3'(s) && k < 200) begin
         drive(0, 0, 0, 0);
         k++;
      end
      check(tag, state, s);
   endtask

   task automatic buy(input logic [3:0] sel, input int v);
      cur_sel = sel;
      coin(v);
      set_conf(1);
      set_conf(0);
      wait_state(S_IDLE, "buy_idle");
   endtask

   initial begin
      rst_n = 1'b0; clr_sales = 0; coin1 = 0; coin5 = 0; coin10 = 0;
      confirm = 0; ticket_sel = '0;
      cur_sel = '0; cur_conf = 0;
      model_reset();
      #12;
      check("rst_state", state, 0);
      check("rst_paid", paid, 0);
      check("rst_change", change, 0);
      check("rst_sales", sales, 0);
      check("rst_ticket", ticket_out, 0);
      check("rst_reject", coin_reject, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: cheapest ticket with a 5 yuan coin
      cur_sel = 4'b0001;
      coin(5);
      check("T1_paid", paid, 5);
      set_conf(1);
      check("T1_ticket", ticket_out, 1);
      drive(0, 0, 0, 0);
      check("T1_change", change, 3);
      check("T1_sales", sales, 2);
      set_conf(0);
      wait_state(S_IDLE, "T1_idle");

      // T2: underpaid -> ERR, top up, buy
      cur_sel = 4'b1000;
      repeat (3) coin(1);
      set_conf(1);
      check("T2_err", err, 1);
      wait_state(S_COLLECT, "T2_back");
      check("T2_paid", paid, 3);
      set_conf(0);
      coin(5);
      set_conf(1);
      check("T2_ticket", ticket_out, 1);
      drive(0, 0, 0, 0);
      check("T2_change", change, 0);
      check("T2_sales", sales, 10);
      set_conf(0);
      wait_state(S_IDLE, "T2_idle");

      // T3: paid ceiling
      cur_sel = 4'b0100;
      repeat (9) coin(10);
      coin(5);
      check("T3_paid95", paid, 95);
      coin(10);
      check("T3_rej10", coin_reject, 1);
      check("T3_hold95", paid, 95);
      drive(1, 1, 0, 0);
      check("T3_rej6", coin_reject, 1);
      check("T3_hold95b", paid, 95);
      set_conf(1);
      set_conf(0);
      check("T3_change", change, 90);
      wait_state(S_IDLE, "T3_idle");
      repeat (9) coin(10);
      drive(1, 1, 1, 0);
      check("T3_rej16", coin_reject, 1);
      check("T3_hold90", paid, 90);
      coin(5);
      repeat (4) coin(1);
      check("T3_paid99", paid, 99);
      coin(1);
      check("T3_rej1", coin_reject, 1);
      set_conf(1);
      set_conf(0);
      check("T3_change94", change, 94);
      wait_state(S_IDLE, "T3_idle2");

      // T4: invalid selection and clear during dispense
      cur_sel = 4'b0011;
      coin(10);
      check("T4_price", price, 0);
      set_conf(1);
      check("T4_err", err, 1);
      check("T4_noticket", ticket_out, 0);
      wait_state(S_COLLECT, "T4_back");
      check("T4_paid", paid, 10);
      cur_sel = 4'b0001;
      set_conf(0);
      set_conf(1);
      check("T4_dispense", state, S_DISPENSE);
      drive(0, 0, 0, 1);
      check("T4_clr", sales, 0);
      set_conf(0);
      wait_state(S_IDLE, "T4_idle");

      // T5: sales saturation and coin during SHOW
      repeat (1249) buy(4'b1000, 10);
      check("T5_9992", sales, 9992);
      buy(4'b0010, 5);
      check("T5_9995", sales, 9995);
      cur_sel = 4'b0100;
      coin(5);
      set_conf(1);
      set_conf(0);
      check("T5_sat", sales, 9999);
      drive(1, 0, 0, 0);
      check("T5_show_rej", coin_reject, 1);
      check("T5_show_paid", paid, 5);
      wait_state(S_IDLE, "T5_idle");
      buy(4'b1000, 10);
      check("T5_sat2", sales, 9999);

      // T6: held confirm after ERR, then async reset mid-transaction
      cur_sel = 4'b1000;
      coin(1);
      set_conf(1);
      wait_state(S_COLLECT, "T6_back");
      idle_n(5);
      check("T6_no_redispense", state, S_COLLECT);
      coin(5);
      coin(1);
      check("T6_paid7", paid, 7);
      @(negedge clk);
      coin1 = 0; coin5 = 0; coin10 = 0; clr_sales = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("T6_rst_state", state, 0);
      check("T6_rst_paid", paid, 0);
      check("T6_rst_sales", sales, 0);
      check("T6_rst_change", change, 0);
      check("T6_rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_n(3);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit c1, c5, c10, clr;
         if (m_st == S_IDLE && $urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 5) == 0) cur_sel = 4'($urandom_range(0, 15));
            else                           cur_sel = 4'b0001 << $urandom_range(0, 3);
         end
         if ($urandom_range(0, 5) == 0) cur_conf = ~cur_conf;
         c1  = ($urandom_range(0, 7) == 0);
         c5  = ($urandom_range(0, 7) == 0);
         c10 = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 49) == 0);
         drive(c1, c5, c10, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
